// File: rtl/clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clock_enable_gen
// Purpose  : Divides the master clock into up to four channels. Each channel
//            produces a one-cycle enable strobe and a 50%-duty divided clock
//            level. All channels share one run control: halt, single-step
//            (one channel-0 period) and resync (reload to start phases).
//            Channel 0 is the CPU channel; its strobes are also counted.
// Ports    : clk_in     - master clock (single clock domain)
//            rst_n      - asynchronous active-low reset
//            halt_i     - level, freezes all channels while high
//            step_i     - pulse, while halted runs one channel-0 period
//            resync_i   - synchronous reload of all counters to PHASEk
//            strobe_o   - per-channel one-cycle enable (registered)
//            clk_o      - per-channel divided clock level (registered)
//            halted_o   - high in cycles where counters are frozen
//            cyc_cnt_o  - count of channel-0 strobes, wraps
// Revision : 1.0 - initial release
// ============================================================================
module clock_enable_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8,
  parameter int DIV0   = 12,
  parameter int DIV1   = 4,
  parameter int DIV2   = 6,
  parameter int DIV3   = 2,
  parameter int PHASE0 = 0,
  parameter int PHASE1 = 0,
  parameter int PHASE2 = 0,
  parameter int PHASE3 = 0,
  parameter int CYC_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              halt_i,
  input  logic              step_i,
  input  logic              resync_i,
  output logic [NUM_CH-1:0] strobe_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic              halted_o,
  output logic [CYC_W-1:0]  cyc_cnt_o
);

  // --------------------------------------------------------------------------
  // Shared run control
  // --------------------------------------------------------------------------
  logic              stepping_q, stepping_d;
  logic              halted_q, halted_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;

  // Per-channel "counter is at its last value" flags and registered outputs.
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_strobe;
  logic [NUM_CH-1:0] w_clk;

  // Counters advance when free-running, or when a single-step is in flight
  // even though halt_i is still high.
  logic w_run;
  assign w_run = !halt_i || stepping_q;

  always_comb begin
    stepping_d = stepping_q;
    halted_d   = halted_q;
    cyc_d      = cyc_q;

    if (resync_i) begin
      // Resync dominates halt and step; the frozen flag simply follows halt.
      stepping_d = 1'b0;
      halted_d   = halt_i;
      cyc_d      = '0;
    end else if (w_run) begin
      halted_d = 1'b0;
      if (w_wrap[0]) begin
        cyc_d = cyc_q + 1'b1;
      end
      // A step ends on the edge that loads the channel-0 strobe; dropping
      // halt mid-step also ends it and leaves the block free-running.
      // Repeated step_i pulses during a step fall through here untouched.
      stepping_d = stepping_q && halt_i && !w_wrap[0];
    end else begin
      halted_d = 1'b1;
      if (halt_i && step_i) begin
        stepping_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stepping_q <= 1'b0;
      halted_q   <= 1'b0;
      cyc_q      <= '0;
    end else begin
      stepping_q <= stepping_d;
      halted_q   <= halted_d;
      cyc_q      <= cyc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel dividers
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Pick this channel's ratio and start phase.
    localparam int DIVK = (k == 0) ? DIV0 :
                          (k == 1) ? DIV1 :
                          (k == 2) ? DIV2 : DIV3;
    localparam int PHK  = (k == 0) ? PHASE0 :
                          (k == 1) ? PHASE1 :
                          (k == 2) ? PHASE2 : PHASE3;
    // Clock level is high for the first ceil(DIV/2) counts of each period,
    // so odd ratios put the extra cycle in the high phase.
    localparam int HALF = (DIVK + 1) / 2;

    localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(DIVK - 1);
    localparam logic [CNT_W-1:0] PHASE_V = CNT_W'(PHK);
    localparam logic [CNT_W-1:0] HALF_V  = CNT_W'(HALF);
    localparam logic             CLK_RST = (PHK < HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             strobe_q, strobe_d;
    logic             clk_q, clk_d;

    assign w_wrap[k]   = (cnt_q == LAST_V);
    assign w_strobe[k] = strobe_q;
    assign w_clk[k]    = clk_q;

    always_comb begin
      cnt_inc  = w_wrap[k] ? '0 : cnt_q + 1'b1;
      cnt_d    = cnt_q;
      clk_d    = clk_q;
      strobe_d = 1'b0;

      if (resync_i) begin
        cnt_d = PHASE_V;
        clk_d = CLK_RST;
      end else if (w_run) begin
        cnt_d    = cnt_inc;
        strobe_d = w_wrap[k];
        // Level is derived from the next count so it rises with the strobe.
        clk_d    = (cnt_inc < HALF_V);
      end
      // Frozen: counter and level hold, strobe drops.
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= PHASE_V;
        strobe_q <= 1'b0;
        clk_q    <= CLK_RST;
      end else begin
        cnt_q    <= cnt_d;
        strobe_q <= strobe_d;
        clk_q    <= clk_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  assign strobe_o  = w_strobe;
  assign clk_o     = w_clk;
  assign halted_o  = halted_q;
  assign cyc_cnt_o = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_enable_gen
// Purpose  : Self-checking bench for clock_enable_gen. Two instances share
//            the stimulus: A uses default ratios, B overrides DIV1=5 and
//            PHASE1=2. Expected outputs come from an elapsed-cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_enable_gen;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        halt   = 1'b0;
  logic        step   = 1'b0;
  logic        resync = 1'b0;

  logic [2:0]  a_strobe, a_clk, b_strobe, b_clk;
  logic        a_halted, b_halted;
  logic [31:0] a_cyc, b_cyc;

  always #5 clk_in = ~clk_in;

  clock_enable_gen u_a (
    .clk_in(clk_in), .rst_n(rst_n), .halt_i(halt), .step_i(step),
    .resync_i(resync), .strobe_o(a_strobe), .clk_o(a_clk),
    .halted_o(a_halted), .cyc_cnt_o(a_cyc)
  );

  clock_enable_gen #(.DIV1(5), .PHASE1(2)) u_b (
    .clk_in(clk_in), .rst_n(rst_n), .halt_i(halt), .step_i(step),
    .resync_i(resync), .strobe_o(b_strobe), .clk_o(b_clk),
    .halted_o(b_halted), .cyc_cnt_o(b_cyc)
  );

  // --------------------------------------------------------------------------
  // Reference model: every channel of both instances has seen the same
  // number of running edges since the last reset/resync (m_n); a channel's
  // position in its period is (PHASE + m_n) mod DIV.
  // --------------------------------------------------------------------------
  localparam int DA [3] = '{12, 4, 6};
  localparam int PA [3] = '{0, 0, 0};
  localparam int DB [3] = '{12, 5, 6};
  localparam int PB [3] = '{0, 2, 0};

  int          m_n;
  bit          m_ran;
  bit          m_step;
  bit          m_halted;
  logic [31:0] m_cyc;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;

  function automatic logic [2:0] m_strobe(input bit b);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) begin
      r[k] = m_ran && (((b ? PB[k] : PA[k]) + m_n) % (b ? DB[k] : DA[k]) == 0);
    end
    return r;
  endfunction

  function automatic logic [2:0] m_clk(input bit b);
    logic [2:0] r;
    int d;
    for (int k = 0; k < 3; k++) begin
      d = b ? DB[k] : DA[k];
      r[k] = (((b ? PB[k] : PA[k]) + m_n) % d) < ((d + 1) / 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_ran = 0; m_step = 0; m_halted = 0; m_cyc = '0;
  endtask

  task automatic model_step();
    bit run, s0;
    run = !halt || m_step;
    if (resync) begin
      m_n = 0; m_ran = 0; m_step = 0; m_cyc = '0; m_halted = halt;
    end else if (run) begin
      m_n++;
      m_ran = 1;
      m_halted = 0;
      s0 = ((PA[0] + m_n) % DA[0] == 0);
      if (s0) m_cyc++;
      m_step = m_step && halt && !s0;
    end else begin
      m_ran = 0;
      m_halted = 1;
      if (halt && step) m_step = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (rst_n) model_step();
    #1;
    edge_no++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; halt = 1'b0; step = 1'b0; resync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk_in); #1;
    tests++;
    if ({a_strobe, a_clk, a_halted, a_cyc} !== {3'b000, 3'b111, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL reset_a: got %h required %h", {a_strobe, a_clk, a_halted, a_cyc},
               {3'b000, 3'b111, 1'b0, 32'd0});
    end
    tests++;
    if ({b_strobe, b_clk, b_halted, b_cyc} !== {3'b000, 3'b111, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL reset_b: got %h required %h", {b_strobe, b_clk, b_halted, b_cyc},
               {3'b000, 3'b111, 1'b0, 32'd0});
    end
  endtask

  task automatic test_free_run();
    int cnt_a [3];
    int first0, first_b1, cnt_b1, clk0_hi, clk_b1_hi;
    cnt_a = '{0, 0, 0};
    first0 = -1; first_b1 = -1; cnt_b1 = 0; clk0_hi = 0; clk_b1_hi = 0;
    do_reset();
    for (int i = 1; i <= 120; i++) begin
      tick();
      tests++;
      if ({a_strobe, a_clk, a_halted, a_cyc} !== {m_strobe(0), m_clk(0), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL free_run_a edge %0d: got %h required %h", edge_no,
                 {a_strobe, a_clk, a_halted, a_cyc}, {m_strobe(0), m_clk(0), m_halted, m_cyc});
      end
      tests++;
      if ({b_strobe, b_clk, b_halted, b_cyc} !== {m_strobe(1), m_clk(1), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL free_run_b edge %0d: got %h required %h", edge_no,
                 {b_strobe, b_clk, b_halted, b_cyc}, {m_strobe(1), m_clk(1), m_halted, m_cyc});
      end
      for (int k = 0; k < 3; k++) if (a_strobe[k]) cnt_a[k]++;
      if (a_strobe[0] && first0 < 0) first0 = i;
      if (b_strobe[1] && first_b1 < 0) first_b1 = i;
      if (b_strobe[1]) cnt_b1++;
      if (a_clk[0]) clk0_hi++;
      if (b_clk[1]) clk_b1_hi++;
    end
    tests++;
    if (first0 != 12) begin
      fails++; $display("FAIL first_strobe0: got edge %0d required 12", first0);
    end
    tests++;
    if (cnt_a[0] != 10 || cnt_a[1] != 30 || cnt_a[2] != 20) begin
      fails++;
      $display("FAIL strobe_totals: got %0d/%0d/%0d required 10/30/20", cnt_a[0], cnt_a[1], cnt_a[2]);
    end
    tests++;
    if (a_cyc !== 32'd10) begin
      fails++; $display("FAIL cyc_cnt_free: got %0d required 10", a_cyc);
    end
    tests++;
    if (clk0_hi != 60) begin
      fails++; $display("FAIL clk0_duty: got %0d high edges required 60", clk0_hi);
    end
    tests++;
    if (first_b1 != 3 || cnt_b1 != 24) begin
      fails++;
      $display("FAIL div5_strobes: got first %0d count %0d required first 3 count 24", first_b1, cnt_b1);
    end
    tests++;
    if (clk_b1_hi != 72) begin
      fails++; $display("FAIL div5_duty: got %0d high edges required 72", clk_b1_hi);
    end
  endtask

  task automatic test_halt();
    logic [2:0] clk_frozen;
    int next0;
    next0 = -1;
    do_reset();
    repeat (17) tick();
    clk_frozen = a_clk;
    halt = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      tests++;
      if ({a_strobe, a_clk, a_halted} !== {3'b000, clk_frozen, 1'b1}) begin
        fails++;
        $display("FAIL halt_frozen edge %0d: got %b required %b", edge_no,
                 {a_strobe, a_clk, a_halted}, {3'b000, clk_frozen, 1'b1});
      end
    end
    halt = 1'b0;
    for (int i = 0; i < 30 && next0 < 0; i++) begin
      tick();
      tests++;
      if ({a_strobe, a_clk, a_halted, a_cyc} !== {m_strobe(0), m_clk(0), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL halt_resume edge %0d: got %h required %h", edge_no,
                 {a_strobe, a_clk, a_halted, a_cyc}, {m_strobe(0), m_clk(0), m_halted, m_cyc});
      end
      if (a_strobe[0]) next0 = edge_no;
    end
    tests++;
    if (next0 != 74) begin
      fails++; $display("FAIL halt_next_strobe0: got edge %0d required 74", next0);
    end
  endtask

  task automatic test_step();
    int running;
    int cnt_s [3];
    logic [31:0] cyc_before;
    running = 0;
    cnt_s = '{0, 0, 0};
    do_reset();
    repeat (12) tick();
    halt = 1'b1;
    repeat (3) tick();
    cyc_before = a_cyc;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step = (i == 4);
      tick();
      tests++;
      if ({a_strobe, a_clk, a_halted, a_cyc} !== {m_strobe(0), m_clk(0), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL step_cycle edge %0d: got %h required %h", edge_no,
                 {a_strobe, a_clk, a_halted, a_cyc}, {m_strobe(0), m_clk(0), m_halted, m_cyc});
      end
      if (!a_halted) running++;
      for (int k = 0; k < 3; k++) if (a_strobe[k]) cnt_s[k]++;
    end
    step = 1'b0;
    tests++;
    if (running != 12) begin
      fails++; $display("FAIL step_running: got %0d cycles required 12", running);
    end
    tests++;
    if (cnt_s[0] != 1 || cnt_s[1] != 3 || cnt_s[2] != 2) begin
      fails++;
      $display("FAIL step_strobes: got %0d/%0d/%0d required 1/3/2", cnt_s[0], cnt_s[1], cnt_s[2]);
    end
    tests++;
    if (a_cyc !== cyc_before + 32'd1 || a_halted !== 1'b1) begin
      fails++;
      $display("FAIL step_end: got cyc %0d halted %b required cyc %0d halted 1", a_cyc, a_halted,
               cyc_before + 32'd1);
    end
    halt = 1'b0;
  endtask

  task automatic test_resync();
    int first0, first1;
    first0 = -1; first1 = -1;
    do_reset();
    repeat (31) tick();
    halt = 1'b1;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    tests++;
    if ({a_strobe, a_clk, a_halted, a_cyc} !== {3'b000, 3'b111, 1'b1, 32'd0}) begin
      fails++;
      $display("FAIL resync_state: got %h required %h", {a_strobe, a_clk, a_halted, a_cyc},
               {3'b000, 3'b111, 1'b1, 32'd0});
    end
    repeat (3) tick();
    halt = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      tests++;
      if ({b_strobe, b_clk, b_halted, b_cyc} !== {m_strobe(1), m_clk(1), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL resync_b edge %0d: got %h required %h", edge_no,
                 {b_strobe, b_clk, b_halted, b_cyc}, {m_strobe(1), m_clk(1), m_halted, m_cyc});
      end
      if (a_strobe[0] && first0 < 0) first0 = i;
      if (a_strobe[1] && first1 < 0) first1 = i;
    end
    tests++;
    if (first0 != 12 || first1 != 4) begin
      fails++;
      $display("FAIL resync_latency: got %0d/%0d required 12/4", first0, first1);
    end
  endtask

  task automatic test_async_reset();
    int cnt0, first0;
    cnt0 = 0; first0 = -1;
    do_reset();
    repeat (12) tick();
    halt = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a_strobe, a_clk, a_halted, a_cyc, b_clk} !== {3'b000, 3'b111, 1'b0, 32'd0, 3'b111}) begin
      fails++;
      $display("FAIL async_reset: got %h required %h", {a_strobe, a_clk, a_halted, a_cyc, b_clk},
               {3'b000, 3'b111, 1'b0, 32'd0, 3'b111});
    end
    model_reset();
    halt = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    edge_no = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      tests++;
      if ({a_strobe, a_clk, a_halted, a_cyc} !== {m_strobe(0), m_clk(0), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL after_reset edge %0d: got %h required %h", edge_no,
                 {a_strobe, a_clk, a_halted, a_cyc}, {m_strobe(0), m_clk(0), m_halted, m_cyc});
      end
      if (a_strobe[0]) cnt0++;
      if (a_strobe[0] && first0 < 0) first0 = i;
    end
    tests++;
    if (first0 != 12 || cnt0 != 2) begin
      fails++;
      $display("FAIL after_reset_strobe0: got first %0d count %0d required 12 and 2", first0, cnt0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      step   = ($urandom_range(0, 5) == 0);
      resync = ($urandom_range(0, 49) == 0);
      tick();
      tests++;
      if ({a_strobe, a_clk, a_halted, a_cyc} !== {m_strobe(0), m_clk(0), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL random_a edge %0d: got %h required %h", edge_no,
                 {a_strobe, a_clk, a_halted, a_cyc}, {m_strobe(0), m_clk(0), m_halted, m_cyc});
      end
      tests++;
      if ({b_strobe, b_clk, b_halted, b_cyc} !== {m_strobe(1), m_clk(1), m_halted, m_cyc}) begin
        fails++;
        $display("FAIL random_b edge %0d: got %h required %h", edge_no,
                 {b_strobe, b_clk, b_halted, b_cyc}, {m_strobe(1), m_clk(1), m_halted, m_cyc});
      end
    end
    halt = 1'b0; step = 1'b0; resync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_halt();
    test_step();
    test_resync();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
